// File: rtl/network_pkg.sv
// Shared types and constants for the accumulate-and-requantize datapath.
package network_pkg;

  localparam int unsigned DEF_PROD_W = 30;
  localparam int unsigned DEF_LEN_W  = 16;
  localparam int unsigned DEF_ACC_W  = 46;
  localparam int unsigned DEF_OUT_W  = 16;

  typedef enum logic [1:0] {IDLE, ACC, ROUND, OUT} acc_state_t;

  function automatic int out_max(int unsigned w);
    return (1 << (w - 1)) - 1;
  endfunction

  function automatic int out_min(int unsigned w);
    return -(1 << (w - 1));
  endfunction

  localparam int OUT_MAX = out_max(DEF_OUT_W);
  localparam int OUT_MIN = out_min(DEF_OUT_W);

endpackage

// File: rtl/network_round_sat.sv
// Round-half-up arithmetic right shift followed by signed saturation to OUT_W bits.
module network_round_sat
  import network_pkg::*;
#(
  parameter int unsigned AW    = DEF_ACC_W + 2,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic signed [AW-1:0]    acc,
  input  logic        [4:0]       shift,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  localparam logic signed [AW-1:0] Max = AW'(out_max(OUT_W));
  localparam logic signed [AW-1:0] Min = AW'(out_min(OUT_W));

  logic signed [AW-1:0] half;
  logic signed [AW-1:0] rounded;

  always_comb begin
    // half is 2^(shift-1), or zero when shift is zero
    half    = (AW'(1) << shift) >> 1;
    rounded = (acc + half) >>> shift;
    res     = rounded[OUT_W-1:0];
    sat     = 1'b0;
    if (rounded > Max) begin
      res = Max[OUT_W-1:0];
      sat = 1'b1;
    end else if (rounded < Min) begin
      res = Min[OUT_W-1:0];
      sat = 1'b1;
    end
  end

endmodule

// File: rtl/network_acc_requant.sv
// Burst accumulate of signed products plus bias, then round/shift/saturate to OUT_W.
// Optional NETWORK_ACC_RELU_EN clamps negative results to zero after saturation.
module network_acc_requant
  import network_pkg::*;
#(
  parameter int unsigned PROD_W = DEF_PROD_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned ACC_W  = DEF_ACC_W,
  parameter int unsigned OUT_W  = DEF_OUT_W
) (
  input  logic                     ap_clk,
  input  logic                     ap_rst,
  input  logic                     start,
  input  logic        [LEN_W-1:0]  cfg_len,
  input  logic        [4:0]        cfg_shift,
  input  logic signed [OUT_W-1:0]  cfg_bias,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [PROD_W-1:0] s_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic signed [OUT_W-1:0]  m_data,
  output logic                     m_sat,
  output logic                     busy
);

  // Two guard bits: bias <<< 31 alone can exceed ACC_W.
  localparam int unsigned AW = ACC_W + 2;

  acc_state_t              state_q, state_d;
  logic [LEN_W-1:0]        len_q, len_d;
  logic [LEN_W-1:0]        cnt_q, cnt_d;
  logic [4:0]              shift_q, shift_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [OUT_W-1:0] data_q, data_d;
  logic                    sat_q, sat_d;
  logic signed [OUT_W-1:0] rs_res;
  logic                    rs_sat;

  network_round_sat #(
    .AW   (AW),
    .OUT_W(OUT_W)
  ) u_round_sat (
    .acc  (acc_q),
    .shift(shift_q),
    .res  (rs_res),
    .sat  (rs_sat)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    data_d  = data_q;
    sat_d   = sat_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = cfg_len;
          shift_d = cfg_shift;
          acc_d   = {{(AW - OUT_W){cfg_bias[OUT_W-1]}}, cfg_bias} <<< cfg_shift;
          cnt_d   = '0;
          state_d = (cfg_len == '0) ? ROUND : ACC;
        end
      end
      ACC: begin
        if (s_valid) begin
          acc_d = acc_q + AW'(s_data);
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_q == len_q - LEN_W'(1)) state_d = ROUND;
        end
      end
      ROUND: begin
        data_d = rs_res;
`ifdef NETWORK_ACC_RELU_EN
        if (rs_res[OUT_W-1]) data_d = '0;
`endif
        sat_d   = rs_sat;
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      shift_q <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      sat_q   <= sat_d;
    end
  end

  assign s_ready = (state_q == ACC);
  assign m_valid = (state_q == OUT);
  assign busy    = (state_q != IDLE);
  assign m_data  = data_q;
  assign m_sat   = sat_q;

endmodule

// File: tb/tb_network_acc_requant.sv
// Self-checking bench for network_acc_requant: directed cases plus randomized bursts.
module tb_network_acc_requant;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        start;
  logic [15:0] cfg_len;
  logic [4:0]  cfg_shift;
  logic [15:0] cfg_bias;
  logic        s_valid;
  logic        s_ready;
  logic [29:0] s_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic        m_sat;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int prods[$];

  network_acc_requant dut (
    .ap_clk   (ap_clk),
    .ap_rst   (ap_rst),
    .start    (start),
    .cfg_len  (cfg_len),
    .cfg_shift(cfg_shift),
    .cfg_bias (cfg_bias),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data),
    .m_sat    (m_sat),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact sum of bias*2^shift and products, round half up, clamp.
  function automatic void model(input int len, input int shift, input int bias,
                                output longint data, output bit sat);
    longint a;
    a = longint'(bias) * (longint'(1) << shift);
    for (int i = 0; i < len; i++) a += longint'(prods[i]);
    if (shift != 0) a = (a + (longint'(1) << (shift - 1))) >>> shift;
    sat = 1'b0;
    if (a > 32767) begin
      a   = 32767;
      sat = 1'b1;
    end else if (a < -32768) begin
      a   = -32768;
      sat = 1'b1;
    end
`ifdef NETWORK_ACC_RELU_EN
    if (a < 0) a = 0;
`endif
    data = a;
  endfunction

  // Called #1 after a rising edge; returns #1 after the edge that completes the output handshake.
  task automatic run_burst(input int len, input int shift, input int bias, input int hold,
                           input bit poke, output longint data, output bit sat);
    int acc_cnt;
    int edges;
    bit hs;
    cfg_len   = 16'(len);
    cfg_shift = 5'(shift);
    cfg_bias  = 16'(bias);
    start     = 1'b1;
    @(posedge ap_clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    acc_cnt = 0;
    edges   = 0;
    while (acc_cnt < len && edges < 1000) begin
      s_valid = ($urandom_range(0, 3) != 0);
      s_data  = s_valid ? 30'(prods[acc_cnt]) : 30'($urandom);
      hs      = s_valid && s_ready;
      @(posedge ap_clk);
      #1;
      edges++;
      if (hs) acc_cnt++;
    end
    s_valid = 1'b0;
    chk("products_accepted", acc_cnt, len);
    if (len == 0) chk("no_s_ready_len0", s_ready, 0);
    chk("not_valid_in_round", m_valid, 0);
    edges = 0;
    while (!m_valid && edges < 20) begin
      @(posedge ap_clk);
      #1;
      edges++;
    end
    chk("out_latency", edges, 1);
    data = longint'($signed(m_data));
    sat  = m_sat;
    for (int k = 0; k < hold; k++) begin
      if (poke && k == 1) begin
        cfg_len   = 16'd0;
        cfg_shift = 5'd0;
        cfg_bias  = 16'd1234;
        start     = 1'b1;
      end
      @(posedge ap_clk);
      #1;
      start = 1'b0;
      chk("hold_valid", m_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_data", $signed(m_data), data);
      chk("hold_sat", m_sat, sat);
    end
    m_ready = 1'b1;
    @(posedge ap_clk);
    #1;
    m_ready = 1'b0;
    chk("idle_after_out", busy, 0);
    chk("valid_drop", m_valid, 0);
  endtask

  initial begin
    longint d;
    longint ed;
    bit     s;
    bit     es;
    int     len;
    int     shift;
    int     bias;
    int     p;

    ap_rst    = 1'b1;
    start     = 1'b0;
    cfg_len   = '0;
    cfg_shift = '0;
    cfg_bias  = '0;
    s_valid   = 1'b0;
    s_data    = '0;
    m_ready   = 1'b0;
    #3;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_sat", m_sat, 0);
    chk("rst_busy", busy, 0);
    #9;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;

    prods = '{8192, 8192, 8192};
    run_burst(3, 13, 0, 2, 0, d, s);
    chk("sum3_data", d, 3);
    chk("sum3_sat", s, 0);

    prods = '{4096};
    run_burst(1, 13, 0, 0, 0, d, s);
    chk("round_pos_half", d, 1);
    prods = '{-4096};
    run_burst(1, 13, 0, 0, 0, d, s);
    chk("round_neg_half", d, 0);
    prods = '{-4097};
    run_burst(1, 13, 0, 0, 0, d, s);
    chk("round_neg_over", d, -1);

    prods = '{536870911};
    run_burst(1, 0, 0, 0, 0, d, s);
    chk("sat_hi_data", d, 32767);
    chk("sat_hi_flag", s, 1);
    prods = '{-536870912};
    run_burst(1, 0, 0, 0, 0, d, s);
`ifdef NETWORK_ACC_RELU_EN
    chk("sat_lo_data", d, 0);
`else
    chk("sat_lo_data", d, -32768);
`endif
    chk("sat_lo_flag", s, 1);

    prods = {};
    run_burst(0, 4, 5, 0, 0, d, s);
    chk("len0_data", d, 5);
    chk("len0_sat", s, 0);

    prods = '{100, 200};
    run_burst(2, 0, 0, 5, 1, d, s);
    chk("bp_data", d, 300);

    // Abort a 4-product burst after two products, then check a clean restart.
    cfg_len   = 16'd4;
    cfg_shift = 5'd0;
    cfg_bias  = 16'd0;
    start     = 1'b1;
    @(posedge ap_clk);
    #1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 30'd1000;
    @(posedge ap_clk);
    #1;
    s_data = 30'd2000;
    @(posedge ap_clk);
    #1;
    s_valid = 1'b0;
    #2;
    ap_rst = 1'b1;
    #1;
    chk("midrst_s_ready", s_ready, 0);
    chk("midrst_busy", busy, 0);
    #1;
    ap_rst = 1'b0;
    @(posedge ap_clk);
    #1;
    prods = '{7};
    run_burst(1, 0, 0, 0, 0, d, s);
    chk("after_rst_data", d, 7);
    chk("after_rst_sat", s, 0);

    for (int n = 0; n < 40; n++) begin
      len   = $urandom_range(0, 6);
      shift = (n % 4 == 0) ? $urandom_range(0, 31) : $urandom_range(6, 20);
      bias  = int'($signed(16'($urandom)));
      prods = {};
      for (int i = 0; i < len; i++) begin
        p = int'($signed(30'($urandom)));
        p = p >>> $urandom_range(0, 20);
        prods.push_back(p);
      end
      model(len, shift, bias, ed, es);
      run_burst(len, shift, bias, $urandom_range(0, 3), 0, d, s);
      chk("rand_data", d, ed);
      chk("rand_sat", s, es);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
